// File: rtl/hazard_ctrl_if.sv
// Bus between the ID-stage pipeline control and the hazard/forwarding controller.
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned CNT_W   = 16
);
  logic                      id_valid_i;
  logic [NUM_SRC*REG_AW-1:0] id_rs_i;
  logic [NUM_SRC-1:0]        id_src_used_i;
  logic [REG_AW-1:0]         id_rd_i;
  logic                      id_regwrite_i;
  logic                      id_memread_i;
  logic                      flush_i;
  logic                      freeze_i;
  logic                      stall_o;
  logic                      idex_bubble_o;
  logic                      ifid_flush_o;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o;
  logic [CNT_W-1:0]          stall_cnt_o;
  logic [CNT_W-1:0]          flush_cnt_o;

  modport master (
    output id_valid_i, id_rs_i, id_src_used_i, id_rd_i, id_regwrite_i, id_memread_i,
           flush_i, freeze_i,
    input  stall_o, idex_bubble_o, ifid_flush_o, fwd_sel_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_src_used_i, id_rd_i, id_regwrite_i, id_memread_i,
           flush_i, freeze_i,
    output stall_o, idex_bubble_o, ifid_flush_o, fwd_sel_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Scoreboard-based load-use hazard detection and EX forward-select generation,
// with saturating stall/flush counters for performance debug.
module hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_RDY = 2,
  parameter int unsigned BR_STAGE = 2,
  parameter int unsigned CNT_W    = 16
) (
  input logic         clk_i,
  input logic         rst_i,
  hazard_ctrl_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(DEPTH);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } slot_t;

  slot_t                    slot_q [DEPTH];
  slot_t                    slot_d [DEPTH];
  slot_t                    id_slot_c;
  logic [DEPTH-1:0]         prod_c [NUM_SRC];
  logic [NUM_SRC-1:0]       haz_src_c;
  logic [NUM_SRC*SEL_W-1:0] fwd_c;
  logic [NUM_SRC*SEL_W-1:0] fwd_q;
  logic [CNT_W-1:0]         stall_cnt_q;
  logic [CNT_W-1:0]         flush_cnt_q;
  logic                     hazard_c;
  logic                     accept_c;

  // Producer matrix: slot k writes a nonzero register that source s reads.
  always_comb begin
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        prod_c[s][k] = slot_q[k].v && slot_q[k].wr && (slot_q[k].rd != '0) &&
                       (slot_q[k].rd == bus.id_rs_i[s*REG_AW +: REG_AW]) &&
                       bus.id_src_used_i[s] && bus.id_valid_i;
      end
    end
  end

  // Scan oldest to youngest so the youngest producer decides hazard and select.
  always_comb begin
    haz_src_c = '0;
    fwd_c     = '0;
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (prod_c[s][k]) begin
          haz_src_c[s] = (k + 1) < (slot_q[k].ld ? int'(LOAD_RDY) : 1);
          fwd_c[s*SEL_W +: SEL_W] = (k <= int'(DEPTH) - 2) ? SEL_W'(k + 1) : '0;
        end
      end
    end
  end

  assign hazard_c  = |haz_src_c;
  assign accept_c  = bus.id_valid_i && !hazard_c && !bus.flush_i;

  assign bus.stall_o       = bus.freeze_i | (hazard_c & ~bus.flush_i);
  assign bus.idex_bubble_o = (hazard_c | bus.flush_i) & ~bus.freeze_i;
  assign bus.ifid_flush_o  = bus.flush_i & ~bus.freeze_i;

  // Next scoreboard: shift by one, insert ID, kill the slots younger than the branch.
  always_comb begin
    id_slot_c.v  = accept_c;
    id_slot_c.rd = bus.id_rd_i;
    id_slot_c.wr = bus.id_regwrite_i;
    id_slot_c.ld = bus.id_memread_i;
    slot_d[0]    = id_slot_c;
    for (int k = 1; k < int'(DEPTH); k++) begin
      slot_d[k] = slot_q[k-1];
      if (bus.flush_i && (k < int'(BR_STAGE))) slot_d[k].v = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(DEPTH); k++) slot_q[k] <= '0;
      fwd_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!bus.freeze_i) begin
      for (int k = 0; k < int'(DEPTH); k++) slot_q[k] <= slot_d[k];
      fwd_q <= accept_c ? fwd_c : '0;
      if (hazard_c && !bus.flush_i && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (bus.flush_i && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.fwd_sel_o   = fwd_q;
  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the in-order pipelined CPU.
- Replaces the fixed 5-stage stall/forward logic with a scoreboard of in-flight destinations. Stage depth, source count and load latency are all configurable.
- Sits beside the ID stage. Drives the PC/IF-ID hold, the ID-EX bubble, the IF-ID flush and the EX-stage forwarding mux selects.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, source operands per instruction.
- DEPTH, 3, tracked stages after ID. Slot 0 = EX, slot DEPTH-1 = WB. Legal range 2..7.
- LOAD_RDY, 2, slot from which load data can be forwarded. Legal range 1..DEPTH-1. ALU results are forwardable from slot 1.
- BR_STAGE, 2, slot index + 1 at which branches resolve. Legal range 1..DEPTH-1. Sets how many younger slots a flush kills.
- CNT_W, 16, counter width.
- SEL_W, ceil(log2(DEPTH)) (derived), width of each forward select.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- id_valid_i, in, 1, ID stage holds a real instruction.
- id_rs_i, in, NUM_SRC*REG_AW, source register addresses; source s occupies bits [s*REG_AW +: REG_AW].
- id_src_used_i, in, NUM_SRC, source s is actually read.
- id_rd_i, in, REG_AW, destination register.
- id_regwrite_i, in, 1, instruction writes rd.
- id_memread_i, in, 1, instruction is a load.
- flush_i, in, 1, taken branch/jump resolved this cycle.
- freeze_i, in, 1, global pipeline freeze (e.g. memory wait).
- stall_o, out, 1, hold PC and IF-ID (combinational).
- idex_bubble_o, out, 1, load a bubble into ID-EX (combinational).
- ifid_flush_o, out, 1, clear IF-ID (combinational).
- fwd_sel_o, out, NUM_SRC*SEL_W, per-source EX forward select (registered).
- stall_cnt_o, out, CNT_W, load-use stall cycles.
- flush_cnt_o, out, CNT_W, flush events.

Behaviour:
- Scoreboard: DEPTH slots, each {v, rd, wr, ld}.
- Reset (rst_i=1 at posedge, overrides all other inputs): all slot v=0, fwd_sel_o=0, both counters=0. Combinational outputs then follow the inputs with an empty scoreboard.
- A slot k is a producer for source s when all of the following hold:
  - v=1 and wr=1, and rd != 0;
  - rd == id_rs_i[s];
  - id_src_used_i[s]=1 and id_valid_i=1.
- Register 0 never creates a hazard or a forward.
- Ready slot of a producer: r = LOAD_RDY if ld=1, else 1.
- Hazard: any producer in slot k with k+1 < r, considering only the youngest producer per source.
  - With defaults this is a load in EX while its consumer is in ID: exactly 1 stall cycle.
  - With LOAD_RDY=3, a load costs 2 stall cycles.
- stall_o = freeze_i | (hazard & ~flush_i).
- idex_bubble_o = (hazard | flush_i) & ~freeze_i.
- ifid_flush_o = flush_i & ~freeze_i.
- Flush takes priority over hazard. Freeze takes priority over both.
- Each posedge, when not in reset:
  - freeze_i=1: all state holds, including fwd_sel_o and the counters.
  - Otherwise slots shift, slot[k+1] <= slot[k], and slot[DEPTH-1] retires.
  - slot[0] <= ID instruction if id_valid_i & ~hazard & ~flush_i, else v=0.
  - flush_i=1: in addition, the post-shift slots 0..BR_STAGE-1 get v=0.
- fwd_sel_o[s] is registered alongside the slot[0] load, so it is valid while that instruction is in EX.
  - Value = k+1 for the youngest (lowest k) producer with k <= DEPTH-2; 0 = register file.
  - A producer in slot DEPTH-1 writes the register file this cycle, so it yields 0 (the regfile is write-before-read).
  - fwd_sel_o is forced to 0 when slot[0] receives a bubble.
- Counters (saturating at all-ones; no counting while freeze_i=1):
  - stall_cnt_o += 1 per cycle with hazard & ~flush_i.
  - flush_cnt_o += 1 per cycle with flush_i.
- Simultaneous flush_i + hazard: bubble inserted, no stall, only flush_cnt_o counts.
- Reset mid-stall: scoreboard empties; with an unchanged ID instruction the hazard disappears next cycle.

Test Plan:
- Reset, then issue add r3 (regwrite) followed by sub r4 = r3 - r1 → no stall. fwd_sel_o[0]=1 while sub is in EX, fwd_sel_o[1]=0.
- lw r5 followed by add r6 = r5 + r5 (defaults) → stall_o=1 and idex_bubble_o=1 for exactly 1 cycle. Then fwd_sel_o[0]=fwd_sel_o[1]=2 in EX; stall_cnt_o=1.
- Same sequence with LOAD_RDY=3, DEPTH=4 → 2 stall cycles, then fwd_sel_o=3; stall_cnt_o=2.
- Writes to r0 followed by a read of r0 → no stall, fwd_sel_o=0. Two producers of r7 in slots 0 and 1 → youngest wins, fwd_sel_o=1.
- flush_i pulsed during a load-use hazard → stall_o=0, idex_bubble_o=1, ifid_flush_o=1. Slots 0..1 are invalid next cycle; flush_cnt_o=1, stall_cnt_o unchanged.
- freeze_i held for 3 cycles mid-hazard → stall_o=1, idex_bubble_o=0, scoreboard, fwd_sel_o and counters frozen. Assert rst_i during a stall → all state 0 on the next cycle. Force the counter to 16'hFFFF → it stays at FFFF.
